// File: rtl/mips32_pkg.sv
// Shared MIPS32 fetch-side constants, FSM state type and small helpers
// used by the program-counter sequencer.
package mips32_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'hBFC0_0380;
  localparam logic [31:0] INST_NOP         = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // A jump target must be word aligned; any set low bit traps.
  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: async reset to the boot vector, loads when enabled.
module pc_reg
  import mips32_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] next,
  output logic [ADDR_W-1:0] pc
);

  // PC storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
    end else if (load) begin
      pc <= next;
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// MIPS32 PC sequencer: exception > redirect > PC+4 selection plus a
// single-outstanding instruction-fetch handshake toward decode.
module pc_sequencer
  import mips32_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              exc_valid,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc_out,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  state_e            state_r;
  logic              squash_r;
  logic              imem_req_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic              inst_valid_r;
  logic [31:0]       inst_r;
  logic [ADDR_W-1:0] inst_pc_r;
  logic              addr_err_r;

  logic [ADDR_W-1:0] pc_s;
  logic [ADDR_W-1:0] pc_next_s;
  logic              pc_load_s;
  logic              flush_s;
  logic              misalign_s;

  pc_reg #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load_s),
    .next  (pc_next_s),
    .pc    (pc_s)
  );

  // Next-PC priority mux; flush_s marks a control-flow change this cycle
  always_comb begin
    pc_load_s  = 1'b0;
    pc_next_s  = pc_s;
    flush_s    = 1'b0;
    misalign_s = 1'b0;
    if (state_r == BOOT) begin
      pc_load_s = 1'b0;
    end else if (exc_valid) begin
      flush_s   = 1'b1;
      pc_load_s = 1'b1;
      pc_next_s = EXC_VECTOR;
    end else if (redirect_valid) begin
      flush_s   = 1'b1;
      pc_load_s = 1'b1;
      if (word_misaligned(redirect_target[1:0])) begin
        misalign_s = 1'b1;
        pc_next_s  = EXC_VECTOR;
      end else begin
        pc_next_s  = redirect_target;
      end
    end else if ((state_r == REQ) && imem_ack && !squash_r) begin
      pc_load_s = 1'b1;
      pc_next_s = pc_s + PC_STEP;
    end else begin
      pc_load_s = 1'b0;
    end
  end

  // Fetch FSM; a fresh request always targets the PC being loaded this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= BOOT;
      squash_r     <= 1'b0;
      imem_req_r   <= 1'b0;
      imem_addr_r  <= RESET_VECTOR;
      inst_valid_r <= 1'b0;
      inst_r       <= INST_NOP;
      inst_pc_r    <= '0;
      addr_err_r   <= 1'b0;
    end else begin
      addr_err_r <= misalign_s;
      case (state_r)
        BOOT: begin
          state_r     <= REQ;
          imem_req_r  <= 1'b1;
          imem_addr_r <= pc_s;
        end
        REQ: begin
          if (flush_s) begin
            inst_valid_r <= 1'b0;
            // Without an ack the old address must stay on the bus until it returns
            if (imem_ack) begin
              squash_r    <= 1'b0;
              imem_addr_r <= pc_next_s;
            end else begin
              squash_r    <= 1'b1;
            end
          end else if (imem_ack) begin
            if (squash_r) begin
              squash_r    <= 1'b0;
              imem_addr_r <= pc_next_s;
            end else begin
              inst_r       <= imem_rdata;
              inst_pc_r    <= pc_s;
              inst_valid_r <= 1'b1;
              imem_req_r   <= 1'b0;
              state_r      <= HOLD;
            end
          end else begin
            state_r <= REQ;
          end
        end
        HOLD: begin
          if (flush_s || !stall) begin
            inst_valid_r <= 1'b0;
            state_r      <= REQ;
            imem_req_r   <= 1'b1;
            imem_addr_r  <= pc_next_s;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r      <= BOOT;
          squash_r     <= 1'b0;
          imem_req_r   <= 1'b0;
          inst_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = imem_addr_r;
  assign inst_valid = inst_valid_r;
  assign inst       = inst_r;
  assign inst_pc    = inst_pc_r;
  assign pc_out     = pc_s;
  assign addr_err   = addr_err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// stall/redirect/exception traffic, scored against a transaction-level model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [31:0] EV = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_out;
  logic        addr_err;

  int vectors = 0;
  int miscompares = 0;

  // reference model: architectural PC, held instruction, pending-stale flag
  bit          m_boot, m_hold, m_stale, m_err;
  logic [31:0] m_pc, m_inst, m_inst_pc;

  // memory responder
  bit          mem_busy, rand_lat, req_started;
  int          mem_cnt, mem_lat;
  logic [31:0] mem_addr, last_req, held_pc;
  logic [31:0] req_log[$];

  pc_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_valid       (exc_valid),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .pc_out          (pc_out),
    .addr_err        (addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2000_0000 + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, RV);
    chk({tag, "_ival"}, {31'b0, inst_valid}, 32'd0);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_ipc"}, inst_pc, 32'd0);
    chk({tag, "_pc"}, pc_out, RV);
    chk({tag, "_err"}, {31'b0, addr_err}, 32'd0);
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_hold = 1'b0; m_stale = 1'b0; m_err = 1'b0;
    m_pc = RV; m_inst = 32'd0; m_inst_pc = 32'd0;
    mem_busy = 1'b0; mem_cnt = 0;
  endtask

  // One clock: predict, advance, compare, then let the memory respond.
  task automatic cycle();
    bit ev, mis, deliver;
    logic [31:0] new_pc;
    ev = 1'b0; mis = 1'b0; deliver = 1'b0; new_pc = m_pc;
    if (!m_boot) begin
      if (exc_valid) begin
        ev = 1'b1; new_pc = EV;
      end else if (redirect_valid) begin
        ev = 1'b1;
        mis = (redirect_target[1:0] != 2'b00);
        new_pc = mis ? EV : redirect_target;
      end
      if (imem_ack) begin
        deliver = !ev && !m_stale;
        m_stale = 1'b0;
      end else if (ev && mem_busy) begin
        m_stale = 1'b1;
      end
      if (ev || !stall) m_hold = 1'b0;
      if (deliver) begin
        m_hold = 1'b1;
        m_inst_pc = mem_addr;
        m_inst = mem_word(mem_addr);
        new_pc = mem_addr + 32'd4;
      end
    end
    m_boot = 1'b0;
    m_pc = new_pc;
    m_err = mis;

    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    exc_valid = 1'b0;

    chk("pc_out", pc_out, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_hold});
    chk("addr_err", {31'b0, addr_err}, {31'b0, m_err});
    chk("imem_req", {31'b0, imem_req}, {31'b0, !m_hold});
    if (m_hold) begin
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_inst_pc);
    end

    req_started = 1'b0;
    if (imem_ack) begin
      imem_ack = 1'b0;
      mem_busy = 1'b0;
    end
    if (mem_busy) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, mem_addr);
      if (mem_cnt <= 1) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(mem_addr);
      end else begin
        mem_cnt--;
      end
    end else if (imem_req) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
      chk("req_addr", imem_addr, m_pc);
      req_started = 1'b1;
      last_req = imem_addr;
      req_log.push_back(imem_addr);
    end
  endtask

  task automatic wait_hold(input int max);
    for (int i = 0; i < max && !inst_valid; i++) cycle();
    chk("hold_reached", {31'b0, inst_valid}, 32'd1);
  endtask

  task automatic wait_req(input int max);
    for (int i = 0; i < max && !req_started; i++) cycle();
    chk("req_seen", {31'b0, req_started}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    exc_valid = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    rand_lat = 1'b0; mem_lat = 1; req_started = 1'b0; last_req = 32'd0;
    model_reset();
    #12;
    chk_reset("reset");

    // sequential fetch from the reset vector, zero-wait memory
    req_log.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 40 && req_log.size() < 3; i++) cycle();
    chk("seq_count", req_log.size(), 32'd3);
    chk("seq_addr0", req_log[0], 32'hBFC0_0000);
    chk("seq_addr1", req_log[1], 32'hBFC0_0004);
    chk("seq_addr2", req_log[2], 32'hBFC0_0008);

    // decode back-pressure for five cycles
    wait_hold(10);
    held_pc = m_inst_pc;
    stall = 1'b1;
    repeat (5) cycle();
    stall = 1'b0;
    cycle();
    chk("stall_rel_req", {31'b0, req_started}, 32'd1);
    chk("stall_rel_addr", last_req, held_pc + 32'd4);

    // redirect during a slow fetch squashes the old ack
    mem_lat = 3;
    wait_req(10);
    cycle();
    redirect_valid = 1'b1; redirect_target = 32'h0040_0100;
    cycle();
    chk("redir_pc", pc_out, 32'h0040_0100);
    wait_req(10);
    chk("redir_addr", last_req, 32'h0040_0100);

    // exception beats a simultaneous redirect
    mem_lat = 1;
    wait_hold(20);
    exc_valid = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0040_0200;
    cycle();
    chk("exc_pc", pc_out, EV);
    chk("exc_no_err", {31'b0, addr_err}, 32'd0);

    // misaligned redirect traps with a single addr_err pulse
    wait_hold(20);
    redirect_valid = 1'b1; redirect_target = 32'h0040_0102;
    cycle();
    chk("mis_err", {31'b0, addr_err}, 32'd1);
    chk("mis_addr", last_req, EV);
    cycle();
    chk("mis_err_pulse", {31'b0, addr_err}, 32'd0);

    // PC+4 wraps at the top of the address space
    wait_hold(20);
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    cycle();
    wait_hold(20);
    wait_req(10);
    chk("wrap_addr", last_req, 32'h0000_0000);

    // asynchronous reset mid-fetch with acks during reset and BOOT
    mem_lat = 3;
    wait_req(20);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_async");
    @(posedge clk); #1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk_reset("rst_hold");
    rst_n = 1'b1;
    model_reset();
    cycle();
    chk("boot_req", {31'b0, req_started}, 32'd1);
    chk("boot_addr", last_req, RV);

    // random traffic
    rand_lat = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [31:0] t;
      stall = ($urandom_range(0, 9) < 4);
      r = int'($urandom_range(0, 99));
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      exc_valid = (r < 3);
      redirect_valid = (r >= 3) && (r < 10);
      redirect_target = t;
      cycle();
    end
    stall = 1'b0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Sequences the MIPS32 program counter and the instruction-fetch handshake.
- Sits between the instruction memory port and the decode stage.
- Chooses the next PC with fixed priority: exception > redirect (branch/jump) > sequential PC+4.
- Allows one outstanding fetch, squashes instructions made stale by redirects, and honours decode back-pressure.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC loaded on reset
- EXC_VECTOR, 32'hBFC0_0380, PC loaded on exception or misaligned redirect
- ADDR_W, 32, PC/address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  decode cannot accept an instruction this cycle
- redirect_valid  in  1  one-cycle pulse: branch/jump taken
- redirect_target  in  32  new PC for the redirect
- exc_valid  in  1  one-cycle pulse: take an exception
- imem_req  out  1  fetch request, held until acked
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- inst_valid  out  1  inst/inst_pc valid for decode
- inst  out  32  instruction to decode
- inst_pc  out  32  PC of inst
- pc_out  out  32  current fetch PC (architectural view)
- addr_err  out  1  one-cycle pulse: misaligned redirect target trapped

Behaviour:
- Reset values: state=BOOT, pc=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR, inst_valid=0, inst=0, inst_pc=0, addr_err=0, squash=0.
- BOOT: one cycle after rst_n deasserts, then go to REQ.
- REQ state:
  - imem_req=1, imem_addr=pc.
  - On imem_ack with squash=0: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (modulo 2^32, wrap 0xFFFF_FFFC->0). Go to HOLD.
  - On imem_ack with squash=1: drop the data, clear squash, stay in REQ at the already-updated pc.
- HOLD state:
  - inst_valid=1. inst and inst_pc stay stable while stall=1; no new request is issued.
  - When stall=0, the instruction is consumed. Clear inst_valid, go to REQ with imem_req=1 and imem_addr=pc on the following cycle.
  - Fetch latency is 2 cycles from request to inst_valid with a zero-wait memory.
- Redirect and exception, evaluated every cycle in any state except BOOT:
  - exc_valid=1: pc<=EXC_VECTOR, regardless of redirect_valid.
  - Else redirect_valid=1 and redirect_target[1:0]!=0: pc<=EXC_VECTOR, addr_err pulses 1 cycle.
  - Else redirect_valid=1: pc<=redirect_target.
  - In every case: inst_valid<=0 (current instruction flushed even if stall=1), next state REQ.
  - If a request is outstanding (REQ, imem_req=1, no ack this cycle): set squash=1. imem_req stays high and imem_addr stays at the old address until the ack, which is discarded.
  - If an ack arrives in the same cycle as a redirect or exception: discard that data, squash stays 0, and the next request goes to the new pc.
- Back-to-back redirects while squash=1: the latest one wins; only one ack is discarded.
- pc_out always equals the pc register.
- Async reset mid-fetch: all state cleared immediately. Any later stray imem_ack during BOOT is ignored.

Decomposition:
- Shared package mips32_pkg:
  - RESET_VECTOR/EXC_VECTOR defaults
  - the state enum {BOOT, REQ, HOLD}
  - INST_NOP=32'h0
- One sub-module, pc_reg: 32-bit PC register with async active-low reset to RESET_VECTOR, load enable, and a next-value input.
- The next-PC priority mux and the FSM live in pc_sequencer.

Test Plan:
- Reset, zero-wait memory returning 0x2000_0000+addr, stall=0 -> imem_addr sequence BFC0_0000, BFC0_0004, BFC0_0008; inst_valid 2 cycles after each request; inst_pc matches.
- stall=1 for 5 cycles while inst_valid=1 -> inst/inst_pc constant, imem_req=0 throughout; request for pc+4 on the cycle after stall falls.
- Memory with 3-cycle ack latency; redirect_valid with target 0x0040_0100 one cycle after the request -> old ack dropped (inst_valid stays 0), next imem_addr=0x0040_0100, pc_out=0x0040_0100.
- exc_valid and redirect_valid (0x0040_0200) in the same cycle -> pc=BFC0_0380, no addr_err.
- redirect_target=0x0040_0102 -> addr_err single pulse, next imem_addr=BFC0_0380.
- rst_n low mid-fetch with ack arriving during reset -> outputs at reset values; first request after BOOT is BFC0_0000.
